// File: rtl/paula_int_ctrl_pkg.sv
// Shared chipset defines for the interrupt controller: register addresses,
// INTENA/INTREQ bit positions and the set/clear write helper.
package paula_int_ctrl_pkg;

  // Addresses are chip register offsets >> 1 (reg_address_in carries bits [8:1])
  localparam logic [7:0] ADDR_INTENAR = 8'h0E;  // 0x01C
  localparam logic [7:0] ADDR_INTREQR = 8'h0F;  // 0x01E
  localparam logic [7:0] ADDR_INTENA  = 8'h4D;  // 0x09A
  localparam logic [7:0] ADDR_INTREQ  = 8'h4E;  // 0x09C

  localparam int TBE    = 0;
  localparam int DSKBLK = 1;
  localparam int SOFT   = 2;
  localparam int PORTS  = 3;
  localparam int COPER  = 4;
  localparam int VERTB  = 5;
  localparam int BLIT   = 6;
  localparam int AUD0   = 7;
  localparam int AUD1   = 8;
  localparam int AUD2   = 9;
  localparam int AUD3   = 10;
  localparam int RBF    = 11;
  localparam int DSKSYN = 12;
  localparam int EXTER  = 13;
  localparam int INTEN  = 14;

  localparam int IPL_DELAY_DEF = 2;

  typedef logic [14:0] int_mask_t;

  // Amiga SET/CLR write: bit 15 selects OR-in versus AND-out of bits 14:0
  function automatic int_mask_t set_clr(input int_mask_t cur, input logic [15:0] wdata);
    return wdata[15] ? (cur | wdata[14:0]) : (cur & ~wdata[14:0]);
  endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Maps the gated interrupt mask (bit 14 = INTEN-on-INTREQ) to a 68k IPL level.
module int_prio_enc
  import paula_int_ctrl_pkg::*;
(
  input  logic [14:0] i_act,
  output logic [2:0]  o_level
);

  always_comb begin
    if (i_act[INTEN] | i_act[EXTER])          o_level = 3'd6;
    else if (|i_act[DSKSYN:RBF])              o_level = 3'd5;
    else if (|i_act[AUD3:AUD0])               o_level = 3'd4;
    else if (|i_act[BLIT:COPER])              o_level = 3'd3;
    else if (i_act[PORTS])                    o_level = 3'd2;
    else if (|i_act[SOFT:TBE])                o_level = 3'd1;
    else                                      o_level = 3'd0;
  end

endmodule

// File: rtl/paula_int_ctrl.sv
// Amiga interrupt controller: INTENA/INTREQ registers, priority encoding and a
// fixed-latency IPL pipeline clocked by the 7 MHz enable.
module paula_int_ctrl
  import paula_int_ctrl_pkg::*;
#(
  parameter int IPL_DELAY = IPL_DELAY_DEF  // 1..4
) (
  input  logic        clk,
  input  logic        _reset,
  input  logic        clk7_en,
  input  logic [7:0]  reg_address_in,
  input  logic [15:0] data_in,
  input  logic        wr,
  output logic [15:0] data_out,
  input  logic [13:0] int_pulse,
  input  logic        ciaa_irq,
  input  logic        ciab_irq,
  output logic [2:0]  _ipl,
  output logic [2:0]  int_level
);

  logic [14:0] r_intena;
  logic [14:0] r_intreq;
  logic [2:0]  r_ipl_p [IPL_DELAY];

  logic        w_wr_ena;
  logic        w_wr_req;
  logic [14:0] w_src;
  logic [14:0] w_intreq_wr;
  logic [14:0] w_act;
  logic [2:0]  w_level;

  assign w_wr_ena = clk7_en & wr & (reg_address_in == ADDR_INTENA);
  assign w_wr_req = clk7_en & wr & (reg_address_in == ADDR_INTREQ);

  // CIA lines replace the unused pulse positions and re-assert every tick
  always_comb begin
    w_src        = {1'b0, int_pulse};
    w_src[PORTS] = ciaa_irq;
    w_src[EXTER] = ciab_irq;
  end

  assign w_intreq_wr = w_wr_req ? set_clr(r_intreq, data_in) : r_intreq;

  // Register stage: sources are OR-ed after the CPU write so they win a clear
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      r_intena <= '0;
      r_intreq <= '0;
    end else if (clk7_en) begin
      if (w_wr_ena)
        r_intena <= set_clr(r_intena, data_in);
      r_intreq <= w_intreq_wr | w_src;
    end
  end

  assign w_act[13:0]  = r_intena[INTEN] ? (r_intena[13:0] & r_intreq[13:0]) : 14'd0;
  assign w_act[INTEN] = r_intena[INTEN] & r_intreq[INTEN];

  int_prio_enc u_prio_enc (
    .i_act   (w_act),
    .o_level (w_level)
  );

  // IPL pipeline stages
  always_ff @(posedge clk or negedge _reset) begin
    if (!_reset) begin
      for (int i = 0; i < IPL_DELAY; i++)
        r_ipl_p[i] <= 3'd0;
    end else if (clk7_en) begin
      r_ipl_p[0] <= w_level;
      for (int i = 1; i < IPL_DELAY; i++)
        r_ipl_p[i] <= r_ipl_p[i-1];
    end
  end

  assign int_level = r_ipl_p[IPL_DELAY-1];
  assign _ipl      = ~int_level;

  always_comb begin
    data_out = 16'h0000;
    if (!wr) begin
      case (reg_address_in)
        ADDR_INTENAR: data_out = {1'b0, r_intena};
        ADDR_INTREQR: data_out = {1'b0, r_intreq};
        default:      data_out = 16'h0000;
      endcase
    end
  end

endmodule

// File: tb/tb_paula_int_ctrl.sv
// Bench for paula_int_ctrl: directed vector table, latency/hold/reset sequences
// and randomized traffic against a behavioural model.
module tb_paula_int_ctrl;
  import paula_int_ctrl_pkg::*;

  localparam int D = 2;

  logic        clk = 1'b0;
  logic        _reset;
  logic        clk7_en;
  logic [7:0]  reg_address_in;
  logic [15:0] data_in;
  logic        wr;
  logic [15:0] data_out;
  logic [13:0] int_pulse;
  logic        ciaa_irq;
  logic        ciab_irq;
  logic [2:0]  _ipl;
  logic [2:0]  int_level;

  int checks = 0;
  int failures = 0;

  logic [14:0] m_ena;
  logic [14:0] m_req;
  int          lvlq[$];
  int          m_lvl;

  paula_int_ctrl #(.IPL_DELAY(D)) dut (
    .clk            (clk),
    ._reset         (_reset),
    .clk7_en        (clk7_en),
    .reg_address_in (reg_address_in),
    .data_in        (data_in),
    .wr             (wr),
    .data_out       (data_out),
    .int_pulse      (int_pulse),
    .ciaa_irq       (ciaa_irq),
    .ciab_irq       (ciab_irq),
    ._ipl           (_ipl),
    .int_level      (int_level)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [15:0] d;
    logic [13:0] p;
    bit          ca;
    bit          cb;
    logic [14:0] e_ena;
    logic [14:0] e_req;
    int          e_lvl;
  } vec_t;

  vec_t vt[20];

  function automatic int bit_level(input int b);
    if (b == 13) return 6;
    if (b >= 11) return 5;
    if (b >= 7)  return 4;
    if (b >= 4)  return 3;
    if (b == 3)  return 2;
    return 1;
  endfunction

  function automatic int model_level();
    int lvl = 0;
    if (m_ena[14]) begin
      for (int b = 0; b < 14; b++)
        if (m_ena[b] && m_req[b] && bit_level(b) > lvl) lvl = bit_level(b);
      if (m_req[14]) lvl = 6;
    end
    return lvl;
  endfunction

  function automatic logic [14:0] wmod(input logic [14:0] cur, input logic [15:0] d);
    logic [14:0] r = cur;
    for (int b = 0; b < 15; b++)
      if (d[b]) r[b] = d[15];
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ena = '0;
    m_req = '0;
    lvlq = {};
    for (int i = 0; i < D; i++) lvlq.push_back(0);
    m_lvl = 0;
  endtask

  task automatic tick(input bit en, input bit w, input logic [7:0] a, input logic [15:0] d,
                      input logic [13:0] p, input bit ca, input bit cb);
    logic [14:0] src;
    clk7_en = en; wr = w; reg_address_in = a; data_in = d; int_pulse = p;
    ciaa_irq = ca; ciab_irq = cb;
    @(posedge clk);
    if (en) begin
      if (w && a == ADDR_INTENA) m_ena = wmod(m_ena, d);
      if (w && a == ADDR_INTREQ) m_req = wmod(m_req, d);
      src = {1'b0, p};
      src[3] = ca;
      src[13] = cb;
      m_req = m_req | src;
      lvlq.push_back(model_level());
      m_lvl = lvlq.pop_front();
    end
    #1;
    wr = 1'b0; int_pulse = '0; clk7_en = 1'b0;
    check("int_level", int_level, m_lvl);
    check("_ipl", _ipl, 7 - m_lvl);
  endtask

  task automatic idle(input int n, input bit ca, input bit cb);
    repeat (n) tick(1'b1, 1'b0, 8'h00, 16'h0000, 14'h0, ca, cb);
  endtask

  task automatic read_chk(input string name, input logic [7:0] a, input logic [15:0] exp);
    wr = 1'b0;
    reg_address_in = a;
    #1;
    check(name, data_out, exp);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    bit ca, cb, en, w;
    logic [7:0] a;
    logic [15:0] d;
    logic [13:0] p;

    //            w  addr          data      pulse     ca cb  intena    intreq    lvl
    vt[0]  = '{1, ADDR_INTENA, 16'hC020, 14'h0000, 0, 0, 15'h4020, 15'h0000, 0};
    vt[1]  = '{0, 8'h00,       16'h0000, 14'h0020, 0, 0, 15'h4020, 15'h0020, 3};
    vt[2]  = '{1, ADDR_INTREQ, 16'h0020, 14'h0000, 0, 0, 15'h4020, 15'h0000, 0};
    vt[3]  = '{1, ADDR_INTENA, 16'hC3F8, 14'h0080, 1, 0, 15'h43F8, 15'h0088, 4};
    vt[4]  = '{1, ADDR_INTREQ, 16'h0080, 14'h0000, 1, 0, 15'h43F8, 15'h0008, 2};
    vt[5]  = '{1, ADDR_INTREQ, 16'h0008, 14'h0000, 1, 0, 15'h43F8, 15'h0008, 2};
    vt[6]  = '{1, ADDR_INTREQ, 16'h0008, 14'h0000, 0, 0, 15'h43F8, 15'h0000, 0};
    vt[7]  = '{0, 8'h00,       16'h0000, 14'h3FFF, 0, 0, 15'h43F8, 15'h1FF7, 4};
    vt[8]  = '{1, ADDR_INTENA, 16'h4000, 14'h0000, 0, 0, 15'h03F8, 15'h1FF7, 0};
    vt[9]  = '{1, ADDR_INTENA, 16'hC000, 14'h0000, 0, 0, 15'h43F8, 15'h1FF7, 4};
    vt[10] = '{1, ADDR_INTREQ, 16'h1FF7, 14'h0000, 0, 0, 15'h43F8, 15'h0000, 0};
    vt[11] = '{0, 8'h00,       16'h0000, 14'h0040, 0, 0, 15'h43F8, 15'h0040, 3};
    vt[12] = '{1, ADDR_INTREQ, 16'h0040, 14'h0040, 0, 0, 15'h43F8, 15'h0040, 3};
    vt[13] = '{1, ADDR_INTENA, 16'h7FFF, 14'h0000, 0, 0, 15'h0000, 15'h0040, 0};
    vt[14] = '{1, ADDR_INTENA, 16'hE000, 14'h0000, 0, 1, 15'h6000, 15'h2040, 6};
    vt[15] = '{1, ADDR_INTENA, 16'h2000, 14'h0000, 0, 1, 15'h4000, 15'h2040, 0};
    vt[16] = '{1, ADDR_INTREQ, 16'hC000, 14'h0000, 0, 1, 15'h4000, 15'h6040, 6};
    vt[17] = '{1, 8'h4F,       16'hFFFF, 14'h0000, 0, 1, 15'h4000, 15'h6040, 6};
    vt[18] = '{1, ADDR_INTREQ, 16'h7FFF, 14'h0000, 0, 0, 15'h4000, 15'h0000, 0};
    vt[19] = '{1, ADDR_INTENA, 16'h7FFF, 14'h0000, 0, 0, 15'h0000, 15'h0000, 0};

    _reset = 1'b0; clk7_en = 1'b0; wr = 1'b0; reg_address_in = '0; data_in = '0;
    int_pulse = '0; ciaa_irq = 1'b0; ciab_irq = 1'b0;
    model_reset();
    #1;
    check("rst_ipl", _ipl, 3'b111);
    check("rst_level", int_level, 0);
    read_chk("rst_intenar", ADDR_INTENAR, 16'h0000);
    read_chk("rst_intreqr", ADDR_INTREQR, 16'h0000);
    repeat (3) @(posedge clk);
    #1 _reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      tick(1'b1, vt[i].w, vt[i].a, vt[i].d, vt[i].p, vt[i].ca, vt[i].cb);
      idle(D, vt[i].ca, vt[i].cb);
      check($sformatf("vec%0d_level", i), int_level, vt[i].e_lvl);
      read_chk($sformatf("vec%0d_intenar", i), ADDR_INTENAR, {1'b0, vt[i].e_ena});
      read_chk($sformatf("vec%0d_intreqr", i), ADDR_INTREQR, {1'b0, vt[i].e_req});
    end

    // exact latency: pulse tick plus D more ticks
    tick(1'b1, 1'b1, ADDR_INTENA, 16'hC020, 14'h0, 0, 0);
    idle(D + 1, 0, 0);
    tick(1'b1, 1'b0, 8'h00, 16'h0000, 14'h0020, 0, 0);
    idle(D - 1, 0, 0);
    check("lat_early", _ipl, 3'b111);
    idle(1, 0, 0);
    check("lat_exact", _ipl, 3'b100);
    tick(1'b1, 1'b1, ADDR_INTREQ, 16'h0020, 14'h0, 0, 0);
    idle(D + 1, 0, 0);

    // wr without clk7_en ignored; pipeline frozen while enable low
    tick(1'b1, 1'b0, 8'h00, 16'h0000, 14'h0020, 0, 0);
    repeat (5) tick(1'b0, 1'b1, ADDR_INTENA, 16'h7FFF, 14'h0, 0, 0);
    check("hold_level", int_level, 0);
    read_chk("wr_no_en", ADDR_INTENAR, 16'h4020);
    idle(D, 0, 0);
    check("hold_resume", int_level, 3);
    read_chk("rd_during_wr_sel", ADDR_INTREQR, 16'h0020);
    tick(1'b1, 1'b1, ADDR_INTREQ, 16'h0020, 14'h0, 0, 0);

    // async reset with level 5 showing and level 6 in flight
    tick(1'b1, 1'b1, ADDR_INTENA, 16'hE800, 14'h0, 0, 0);
    tick(1'b1, 1'b0, 8'h00, 16'h0000, 14'h0800, 0, 0);
    idle(D, 0, 0);
    check("pre_rst_level5", int_level, 5);
    tick(1'b1, 1'b0, 8'h00, 16'h0000, 14'h0, 0, 1);
    #1 _reset = 1'b0;
    #1;
    check("async_rst_ipl", _ipl, 3'b111);
    check("async_rst_level", int_level, 0);
    read_chk("async_rst_intreqr", ADDR_INTREQR, 16'h0000);
    model_reset();
    ciab_irq = 1'b0;
    @(posedge clk);
    #1 _reset = 1'b1;
    idle(D + 2, 0, 0);
    check("post_rst_ipl", _ipl, 3'b111);
    read_chk("post_rst_intenar", ADDR_INTENAR, 16'h0000);

    // randomized traffic
    ca = 0; cb = 0;
    for (int n = 0; n < 600; n++) begin
      en = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 4))
        0: a = ADDR_INTENA;
        1: a = ADDR_INTREQ;
        2: a = ADDR_INTENAR;
        3: a = ADDR_INTREQR;
        default: a = 8'($urandom);
      endcase
      d = 16'($urandom);
      p = ($urandom_range(0, 3) == 0) ? 14'(1 << $urandom_range(0, 13)) : 14'h0;
      if ($urandom_range(0, 7) == 0) ca = ~ca;
      if ($urandom_range(0, 7) == 0) cb = ~cb;
      tick(en, w, a, d, p, ca, cb);
      if (n % 4 == 0) begin
        read_chk("rnd_intenar", ADDR_INTENAR, {1'b0, m_ena});
        read_chk("rnd_intreqr", ADDR_INTREQR, {1'b0, m_req});
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
